mine_field_gen: RTL and testbench

- Parametrised sequential mine placer for the minesweeper datapath.
- On a start pulse it takes a snapshot of a ROWS x COLS field of CELL_W-bit cells and clears every bomb bit.
- It then places exactly bomb_count bombs at pseudo-random, non-duplicate positions, one candidate per clock, never on the player's safe cell.
- It sits between the game controller (start/safe cell) and the neighbour-count/display logic, which consume field_out after done.

---
 rtl/mine_field_gen.sv | 132 +++++++++++++
 tb/tb_mine_field_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_field_gen.sv
// Sequential mine placer: snapshots a field, clears bombs, then drops
// bomb_count bombs at LFSR-chosen cells, one candidate per clock.
module mine_field_gen #(
  parameter int          ROWS      = 8,
  parameter int          COLS      = 8,
  parameter int          CELL_W    = 9,
  parameter int          BOMB_BIT  = 2,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 4096,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N + 1),
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FW    = N * CELL_W,
  localparam int TW    = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bomb_count,
  input  logic [RW-1:0]    safe_row,
  input  logic [CW-1:0]    safe_col,
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
  input  logic [FW-1:0]    field_in,
  output logic [FW-1:0]    field_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] placed
);

  typedef enum logic [1:0] {
    IDLE, LOAD, PLACE, DONE
  } state_t;

  state_t state, state_n;

  logic [15:0]      lfsr, lfsr_n;
  logic [TW-1:0]    tries, tries_n;
  logic [CNT_W-1:0] bcnt_q, placed_n;
  logic [IDX_W-1:0] safe_q, cand;
  logic [FW-1:0]    fld_q, field_clr, field_set;
  logic             cand_bomb, accept, too_many, run_end;

  assign lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cand     = lfsr_n[IDX_W-1:0];
  assign tries_n  = tries + TW'(1);
  assign too_many = int'(bomb_count) > N - 1;
  assign accept   = (state == PLACE) && (int'(cand) < N)
                    && !cand_bomb && (cand != safe_q);
  assign placed_n = placed + CNT_W'(accept);
  assign run_end  = (placed_n == bcnt_q) || (tries_n == TW'(MAX_TRIES));

  always_comb begin
    cand_bomb = 1'b0;
    field_clr = fld_q;
    field_set = field_out;
    for (int i = 0; i < N; i++) begin
      field_clr[i*CELL_W+BOMB_BIT] = 1'b0;
      if (cand == IDX_W'(i)) begin
        cand_bomb = field_out[i*CELL_W+BOMB_BIT];
        if (accept) field_set[i*CELL_W+BOMB_BIT] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = too_many ? DONE : LOAD;
      LOAD:  state_n = (bcnt_q == '0) ? DONE : PLACE;
      PLACE: if (run_end) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      field_out <= '0;
      fld_q     <= '0;
      placed    <= '0;
      error     <= 1'b0;
      tries     <= '0;
      bcnt_q    <= '0;
      safe_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (seed_load)
            lfsr <= (seed_in == 16'h0) ? SEED : seed_in;
          if (start) begin
            if (too_many) begin
              error <= 1'b1;
            end else begin
              bcnt_q <= bomb_count;
              safe_q <= IDX_W'(int'(safe_row) * COLS + int'(safe_col));
              fld_q  <= field_in;
            end
          end
        end
        LOAD: begin
          field_out <= field_clr;
          placed    <= '0;
          tries     <= '0;
          error     <= 1'b0;
        end
        PLACE: begin
          lfsr      <= lfsr_n;
          tries     <= tries_n;
          field_out <= field_set;
          placed    <= placed_n;
          // out of draws with bombs still missing
          if (run_end && placed_n != bcnt_q) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == PLACE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mine_field_gen.sv
// Scoreboard bench for mine_field_gen: a reference placer predicts each
// run's field, count, error and latency from the tracked LFSR state.
module tb_mine_field_gen;
  localparam int N  = 64;
  localparam int CW = 9;
  localparam int FW = N * CW;
  localparam int BB = 2;

  logic          clk = 1'b0;
  logic          rst, start, start2, seed_load;
  logic [6:0]    bomb_count, placed, placed2;
  logic [2:0]    safe_row, safe_col;
  logic [15:0]   seed_in;
  logic [FW-1:0] field_in, field_out, field_out2;
  logic          busy, done, error, busy2, done2, error2;

  mine_field_gen dut (
    .clk(clk), .rst(rst), .start(start), .bomb_count(bomb_count),
    .safe_row(safe_row), .safe_col(safe_col), .seed_load(seed_load),
    .seed_in(seed_in), .field_in(field_in), .field_out(field_out),
    .busy(busy), .done(done), .error(error), .placed(placed)
  );

  mine_field_gen #(.MAX_TRIES(16)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .bomb_count(bomb_count),
    .safe_row(safe_row), .safe_col(safe_col), .seed_load(seed_load),
    .seed_in(seed_in), .field_in(field_in), .field_out(field_out2),
    .busy(busy2), .done(done2), .error(error2), .placed(placed2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] f;
    int            placed;
    bit            err;
    int            tries;
    logic [15:0]   lfsr;
  } exp_t;

  exp_t          exp_q[$];
  logic [15:0]   lfsr_m[2];
  logic [FW-1:0] field_m[2];
  int            placed_m[2];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [15:0] step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic exp_t model(input int inst, input int bc,
                                 input int sr, input int sc,
                                 input logic [FW-1:0] fin);
    exp_t e;
    int   c, safe, maxt;
    maxt   = inst ? 16 : 4096;
    e.lfsr = lfsr_m[inst];
    e.tries = 0;
    e.err  = 0;
    if (bc > N - 1) begin
      e.f      = field_m[inst];
      e.placed = placed_m[inst];
      e.err    = 1;
      return e;
    end
    e.f = fin;
    for (int i = 0; i < N; i++) e.f[i*CW+BB] = 1'b0;
    e.placed = 0;
    safe = sr * 8 + sc;
    while (e.placed < bc && !e.err) begin
      e.lfsr = step(e.lfsr);
      e.tries++;
      c = int'(e.lfsr[5:0]);
      if (c != safe && !e.f[c*CW+BB]) begin
        e.f[c*CW+BB] = 1'b1;
        e.placed++;
      end
      if (e.placed < bc && e.tries == maxt) e.err = 1;
    end
    return e;
  endfunction

  function automatic int count_cells(input logic [FW-1:0] f,
                                     input logic [CW-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) if (f[i*CW +: CW] == v) n++;
    return n;
  endfunction

  function automatic int count_bombs(input logic [FW-1:0] f);
    int n = 0;
    for (int i = 0; i < N; i++) if (f[i*CW+BB]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      lfsr_m[i]   = 16'hACE1;
      field_m[i]  = '0;
      placed_m[i] = 0;
    end
  endtask

  task automatic drive_start(input int inst, input logic v);
    if (inst != 0) start2 = v;
    else           start  = v;
  endtask

  task automatic run(input int inst, input int bc, input int sr,
                     input int sc, input logic [FW-1:0] fin,
                     input int dup_at);
    exp_t          e, g;
    int            k, exp_k, busy_bad, extra;
    logic          d, b;
    logic [FW-1:0] fo;
    logic [6:0]    po;
    logic          eo;
    e = model(inst, bc, sr, sc, fin);
    exp_q.push_back(e);
    exp_k = (e.err && e.tries == 0) ? 1 : e.tries + 2;
    @(negedge clk);
    bomb_count = 7'(bc);
    safe_row   = 3'(sr);
    safe_col   = 3'(sc);
    field_in   = fin;
    drive_start(inst, 1'b1);
    busy_bad = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      drive_start(inst, k == dup_at);
      if (k == dup_at) bomb_count = 7'd5;
      d = inst ? done2 : done;
      b = inst ? busy2 : busy;
      if (!d && b !== 1'b1) busy_bad++;
    end while (!d && k < 5000);
    n_cmp++;
    if (k !== exp_k) begin
      n_bad++;
      $display("FAIL latency inst%0d bc%0d: got %0d want %0d",
               inst, bc, k, exp_k);
    end
    n_cmp++;
    if (busy_bad != 0 || b !== 1'b0) begin
      n_bad++;
      $display("FAIL busy inst%0d bc%0d: bad %0d busy@done %b want 0/0",
               inst, bc, busy_bad, b);
    end
    g  = exp_q.pop_front();
    fo = inst ? field_out2 : field_out;
    po = inst ? placed2 : placed;
    eo = inst ? error2 : error;
    n_cmp++;
    if (fo !== g.f) begin
      n_bad++;
      $display("FAIL field inst%0d bc%0d: got %h want %h", inst, bc, fo, g.f);
    end
    n_cmp++;
    if (po !== 7'(g.placed) || eo !== g.err) begin
      n_bad++;
      $display("FAIL status inst%0d bc%0d: placed %0d err %b want %0d %b",
               inst, bc, po, eo, g.placed, g.err);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ((inst ? done2 : done) !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL done_pulse inst%0d: extra %0d want 0", inst, extra);
    end
    lfsr_m[inst]   = g.lfsr;
    field_m[inst]  = g.f;
    placed_m[inst] = g.placed;
  endtask

  task automatic load_seed(input logic [15:0] v);
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = v;
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 2; i++) lfsr_m[i] = (v == 16'h0) ? 16'hACE1 : v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (field_out !== '0 || field_out2 !== '0) begin
      n_bad++;
      $display("FAIL reset_field: got nonzero want 0");
    end
    n_cmp++;
    if ({busy, done, error, placed, busy2, done2, error2, placed2} !== '0)
    begin
      n_bad++;
      $display("FAIL reset_status: got %b %b %b %0d want 0 0 0 0",
               busy, done, error, placed);
    end
  endtask

  task automatic test_basic();
    run(0, 10, 0, 0, '0, 0);
    n_cmp++;
    if (count_cells(field_out, 9'h004) != 10 || field_out[8:0] !== 9'h000)
    begin
      n_bad++;
      $display("FAIL basic_cells: bombs %0d cell00 %h want 10 000",
               count_cells(field_out, 9'h004), field_out[8:0]);
    end
  endtask

  task automatic test_keep_bits();
    logic [FW-1:0] fin, f1;
    for (int i = 0; i < N; i++) fin[i*CW +: CW] = 9'h1FB;
    run(0, 5, 2, 2, fin, 0);
    n_cmp++;
    if (count_cells(field_out, 9'h1FF) != 5 ||
        count_cells(field_out, 9'h1FB) != N - 5) begin
      n_bad++;
      $display("FAIL keep_bits: 1FF %0d 1FB %0d want 5 59",
               count_cells(field_out, 9'h1FF),
               count_cells(field_out, 9'h1FB));
    end
    f1 = field_out;
    run(0, 5, 2, 2, fin, 0);
    n_cmp++;
    if (field_out === f1) begin
      n_bad++;
      $display("FAIL reseed_diff: got same field want different");
    end
  endtask

  task automatic test_full();
    logic [FW-1:0] fin, keep;
    run(0, 63, 3, 4, '0, 0);
    n_cmp++;
    if (count_bombs(field_out) != 63 || field_out[(3*8+4)*CW+BB] !== 1'b0
        || error !== 1'b0) begin
      n_bad++;
      $display("FAIL full63: bombs %0d safe %b err %b want 63 0 0",
               count_bombs(field_out), field_out[(3*8+4)*CW+BB], error);
    end
    keep = field_out;
    for (int i = 0; i < N; i++) fin[i*CW +: CW] = 9'h1FB;
    run(0, 64, 0, 0, fin, 0);
    n_cmp++;
    if (field_out !== keep || error !== 1'b1) begin
      n_bad++;
      $display("FAIL over64: changed %b err %b want 0 1",
               field_out !== keep, error);
    end
  endtask

  task automatic test_seed();
    logic [FW-1:0] f1;
    load_seed(16'h1234);
    run(0, 8, 1, 1, '0, 0);
    f1 = field_out;
    load_seed(16'h1234);
    run(0, 8, 1, 1, '0, 0);
    n_cmp++;
    if (field_out !== f1) begin
      n_bad++;
      $display("FAIL seed_repeat: got %h want %h", field_out, f1);
    end
    test_reset();
    run(0, 8, 1, 1, '0, 0);
    f1 = field_out;
    load_seed(16'h0000);
    run(0, 8, 1, 1, '0, 0);
    n_cmp++;
    if (field_out !== f1) begin
      n_bad++;
      $display("FAIL seed_zero: got %h want %h", field_out, f1);
    end
  endtask

  task automatic test_max_tries();
    run(1, 63, 0, 0, '0, 0);
    n_cmp++;
    if (error2 !== 1'b1 || placed2 >= 7'd63 ||
        count_bombs(field_out2) != int'(placed2)) begin
      n_bad++;
      $display("FAIL max_tries: err %b placed %0d bombs %0d want 1 <63 eq",
               error2, placed2, count_bombs(field_out2));
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic b;
    @(negedge clk);
    bomb_count = 7'd40;
    field_in   = '0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    b   = busy;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    n_cmp++;
    if (b !== 1'b1 || field_out !== '0 || busy !== 1'b0 ||
        placed !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy_before %b busy %b placed %0d want 1 0 0",
               b, busy, placed);
    end
    if (done) pulses++;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL reset_mid_done: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    run(0, 20, 5, 5, '0, 3);
    n_cmp++;
    if (placed !== 7'd20) begin
      n_bad++;
      $display("FAIL back_to_back: placed %0d want 20", placed);
    end
  endtask

  initial begin
    start = 1'b0;
    start2 = 1'b0;
    seed_load = 1'b0;
    seed_in = '0;
    bomb_count = '0;
    safe_row = '0;
    safe_col = '0;
    field_in = '0;
    test_reset();
    test_basic();
    test_keep_bits();
    test_full();
    test_seed();
    test_max_tries();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
